// File: rtl/game_flow_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller_pkg
// Purpose  : Shared game-state type, playfield geometry and helper functions
//            for the pong game sequencer and its consumers.
// Revision : 1.0 - initial release
// ============================================================================
package game_flow_controller_pkg;

  typedef enum logic [1:0] {
    MENU_START = 2'd0,
    SERVE      = 2'd1,
    PLAY       = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  // Playfield geometry, pixels
  localparam int X_PAD_LEFT      = 32;
  localparam int X_PAD_RIGHT     = 600;
  localparam int PAD_WIDTH       = 8;
  localparam int BALL_SIZE       = 8;

  localparam int WIN_SCORE_DEF   = 9;
  localparam int SERVE_TICKS_DEF = 120;

  // Ball has left the field past the left paddle line
  function automatic logic ball_out_left(input logic [10:0] x_ball);
    return x_ball < 11'(X_PAD_LEFT);
  endfunction

  // Ball right edge beyond the right paddle; 12-bit sum so x_ball+BALL_SIZE never wraps
  function automatic logic ball_out_right(input logic [10:0] x_ball);
    return ({1'b0, x_ball} + 12'(BALL_SIZE)) > 12'(X_PAD_RIGHT + PAD_WIDTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_flow_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller_if
// Purpose  : Bundle of frame tick, start button, ball position, scores and the
//            sequencer outputs shared between the controller and the game logic.
// Revision : 1.0 - initial release
// ============================================================================
interface game_flow_controller_if;
  import game_flow_controller_pkg::*;

  logic        timing_tick;
  logic        btn_start;
  logic [10:0] x_ball;
  logic [3:0]  player1_score;
  logic [3:0]  player2_score;
  state_t      state;
  logic        ball_hold;
  logic        serve_dir;
  logic [1:0]  winner;

  // Sequencer side
  modport master (
    input  timing_tick, btn_start, x_ball, player1_score, player2_score,
    output state, ball_hold, serve_dir, winner
  );

  // Game logic side
  modport slave (
    output timing_tick, btn_start, x_ball, player1_score, player2_score,
    input  state, ball_hold, serve_dir, winner
  );

endinterface
`default_nettype wire

// File: rtl/game_flow_controller_btn_edge.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller_btn_edge
// Purpose  : Rising-edge detector for a synchronous, debounced button level.
//            One pulse per press; a held level never re-triggers.
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_controller_btn_edge (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic din,
  output logic      pulse
);

  logic din_q;

  // Remember the previous button level
  always_ff @(posedge clk) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign pulse = din & ~din_q;

endmodule
`default_nettype wire

// File: rtl/game_flow_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller
// Purpose  : Pong game sequencer. Drives the shared game state, holds the
//            ball for each serve, picks the serve direction, detects the
//            winner and returns to the menu on the start button.
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int SERVE_TICKS = SERVE_TICKS_DEF,
  parameter int WIN_SCORE   = WIN_SCORE_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst,
  game_flow_controller_if.master bus
);

  localparam int         CNT_W     = $clog2(SERVE_TICKS);
  localparam logic [3:0] WIN_LIMIT = 4'(WIN_SCORE);

  // Scores settle two ticks into a serve, so shorter serves could miss a point
  if (SERVE_TICKS < 3) begin : g_serve_ticks_check
    $error("game_flow_controller: SERVE_TICKS must be at least 3");
  end
  // score_controller saturates at 9, a higher target could never be reached
  if ((WIN_SCORE > 9) || (WIN_SCORE < 1)) begin : g_win_score_check
    $error("game_flow_controller: WIN_SCORE must be in 1..9");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_q, hold_d;
  logic             dir_q, dir_d;
  logic [1:0]       winner_q, winner_d;
  logic             start_pe;
  logic             serve_done;

  game_flow_controller_btn_edge u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.btn_start),
    .pulse (start_pe)
  );

  assign serve_done = (cnt_q == CNT_W'(SERVE_TICKS - 1));

  // Next-state, serve counter and registered-output values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    unique case (state_q)
      MENU_START: begin
        winner_d = 2'd0;
        if (start_pe) begin
          state_d = SERVE;
          cnt_d   = '0;
          dir_d   = 1'b1;
        end
      end
      SERVE: begin
        if (bus.timing_tick) begin
          if (serve_done) begin
            // Player1 has priority if both somehow reach the target
            if (bus.player1_score >= WIN_LIMIT) begin
              state_d  = GAME_OVER;
              winner_d = 2'd1;
            end else if (bus.player2_score >= WIN_LIMIT) begin
              state_d  = GAME_OVER;
              winner_d = 2'd2;
            end else begin
              state_d = PLAY;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        if (bus.timing_tick) begin
          // Player2 point: serve towards the conceding player1
          if (ball_out_left(bus.x_ball)) begin
            state_d = SERVE;
            dir_d   = 1'b0;
            cnt_d   = '0;
          end else if (ball_out_right(bus.x_ball)) begin
            state_d = SERVE;
            dir_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      GAME_OVER: begin
        if (start_pe) begin
          state_d  = MENU_START;
          winner_d = 2'd0;
        end
      end
      default: state_d = MENU_START;
    endcase
    hold_d = (state_d != PLAY);
  end

  // State, counter and output registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MENU_START;
      cnt_q    <= '0;
      hold_q   <= 1'b1;
      dir_q    <= 1'b1;
      winner_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.ball_hold = hold_q;
  assign bus.serve_dir = dir_q;
  assign bus.winner    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_controller
// Purpose  : Self-checking bench for the pong game sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  localparam int ST = 120;
  localparam int WS = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btn = 1'b0;
  logic [10:0] x = 11'd316;
  logic [3:0]  p1 = 4'd0;
  logic [3:0]  p2 = 4'd0;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the sequencer
  logic [1:0] m_state = 2'd0;
  int         m_cnt = 0;
  logic       m_hold = 1'b1;
  logic       m_dir = 1'b1;
  logic [1:0] m_win = 2'd0;
  logic       m_bq = 1'b0;

  always #5 clk = ~clk;

  game_flow_controller_if bus ();

  assign bus.timing_tick   = tick;
  assign bus.btn_start     = btn;
  assign bus.x_ball        = x;
  assign bus.player1_score = p1;
  assign bus.player2_score = p2;

  game_flow_controller #(.SERVE_TICKS(ST), .WIN_SCORE(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Advance one clock; the model applies the game rules to the inputs seen at the edge
  task automatic step();
    logic [1:0] ns;
    int         nc;
    logic       nd;
    logic [1:0] nw;
    bit         pe;
    pe = btn && !m_bq;
    ns = m_state; nc = m_cnt; nd = m_dir; nw = m_win;
    if (rst) begin
      ns = 2'd0; nc = 0; nd = 1'b1; nw = 2'd0;
    end else begin
      case (m_state)
        2'd0: if (pe) begin ns = 2'd1; nc = 0; nd = 1'b1; end
        2'd1: if (tick) begin
          if (m_cnt == ST - 1) begin
            if (int'(p1) >= WS)      begin ns = 2'd3; nw = 2'd1; end
            else if (int'(p2) >= WS) begin ns = 2'd3; nw = 2'd2; end
            else ns = 2'd2;
          end else nc = m_cnt + 1;
        end
        2'd2: if (tick) begin
          if (int'(x) < X_PAD_LEFT) begin ns = 2'd1; nd = 1'b0; nc = 0; end
          else if (int'(x) + BALL_SIZE > X_PAD_RIGHT + PAD_WIDTH) begin ns = 2'd1; nd = 1'b1; nc = 0; end
        end
        default: if (pe) begin ns = 2'd0; nw = 2'd0; end
      endcase
    end
    @(posedge clk);
    m_state = ns; m_cnt = nc; m_dir = nd; m_win = nw;
    m_bq    = rst ? 1'b0 : btn;
    m_hold  = (ns != 2'd2);
    #1;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    for (int i = 0; i < n; i++) step();
    tick = 1'b0;
  endtask

  task automatic press_start();
    btn = 1'b1; step();
    btn = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; btn = 1'b0; x = 11'd316; p1 = 4'd0; p2 = 4'd0;
    step(); step();
    rst = 1'b0;
    step();
    tests_run++; if (bus.state !== MENU_START) begin tests_failed++; $display("FAIL reset_state got %0d want 0", bus.state); end
    tests_run++; if (bus.ball_hold !== 1'b1) begin tests_failed++; $display("FAIL reset_hold got %b want 1", bus.ball_hold); end
    tests_run++; if (bus.serve_dir !== 1'b1) begin tests_failed++; $display("FAIL reset_dir got %b want 1", bus.serve_dir); end
    tests_run++; if (bus.winner !== 2'd0) begin tests_failed++; $display("FAIL reset_winner got %0d want 0", bus.winner); end
  endtask

  task automatic test_start_held();
    int         entries;
    logic [1:0] prev;
    entries = 0;
    prev = bus.state;
    btn = 1'b1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (prev == 2'd0 && bus.state == SERVE) entries++;
      prev = bus.state;
    end
    tests_run++; if (entries !== 1) begin tests_failed++; $display("FAIL held_start_entries got %0d want 1", entries); end
    tests_run++; if (bus.state !== SERVE) begin tests_failed++; $display("FAIL held_start_state got %0d want 1", bus.state); end
    run_ticks(ST - 1);
    tests_run++; if (bus.state !== SERVE) begin tests_failed++; $display("FAIL serve_not_early got %0d want 1", bus.state); end
    run_ticks(1);
    tests_run++; if (bus.state !== PLAY) begin tests_failed++; $display("FAIL serve_to_play got %0d want 2", bus.state); end
    tests_run++; if (bus.ball_hold !== 1'b0) begin tests_failed++; $display("FAIL play_hold got %b want 0", bus.ball_hold); end
    btn = 1'b0;
    step();
  endtask

  task automatic test_left_exit();
    x = 11'(X_PAD_LEFT - 1); tick = 1'b0;
    step();
    tests_run++; if (bus.state !== PLAY) begin tests_failed++; $display("FAIL left_no_tick got %0d want 2", bus.state); end
    tick = 1'b1;
    step();
    tick = 1'b0; x = 11'd316;
    tests_run++; if (bus.state !== SERVE) begin tests_failed++; $display("FAIL left_exit_state got %0d want 1", bus.state); end
    tests_run++; if (bus.serve_dir !== 1'b0) begin tests_failed++; $display("FAIL left_exit_dir got %b want 0", bus.serve_dir); end
    tests_run++; if (bus.ball_hold !== 1'b1) begin tests_failed++; $display("FAIL left_exit_hold got %b want 1", bus.ball_hold); end
    run_ticks(ST);
    tests_run++; if (bus.state !== PLAY) begin tests_failed++; $display("FAIL reserve_play got %0d want 2", bus.state); end
  endtask

  task automatic test_right_exit();
    x = 11'(X_PAD_RIGHT + PAD_WIDTH - BALL_SIZE); tick = 1'b1;
    step();
    tests_run++; if (bus.state !== PLAY) begin tests_failed++; $display("FAIL right_inside got %0d want 2", bus.state); end
    x = 11'(X_PAD_RIGHT + PAD_WIDTH - BALL_SIZE + 1);
    step();
    tick = 1'b0; x = 11'd316;
    tests_run++; if (bus.state !== SERVE) begin tests_failed++; $display("FAIL right_exit_state got %0d want 1", bus.state); end
    tests_run++; if (bus.serve_dir !== 1'b1) begin tests_failed++; $display("FAIL right_exit_dir got %b want 1", bus.serve_dir); end
  endtask

  task automatic test_p1_win();
    p1 = 4'd8;
    run_ticks(60);
    p1 = 4'd9;
    btn = 1'b1; step(); btn = 1'b0;
    run_ticks(ST - 61);
    tests_run++; if (bus.state !== SERVE) begin tests_failed++; $display("FAIL p1_serve_running got %0d want 1", bus.state); end
    run_ticks(1);
    tests_run++; if (bus.state !== GAME_OVER) begin tests_failed++; $display("FAIL p1_game_over got %0d want 3", bus.state); end
    tests_run++; if (bus.winner !== 2'd1) begin tests_failed++; $display("FAIL p1_winner got %0d want 1", bus.winner); end
    tests_run++; if (bus.ball_hold !== 1'b1) begin tests_failed++; $display("FAIL p1_hold got %b want 1", bus.ball_hold); end
    btn = 1'b1; step();
    tests_run++; if (bus.state !== MENU_START) begin tests_failed++; $display("FAIL p1_menu got %0d want 0", bus.state); end
    tests_run++; if (bus.winner !== 2'd0) begin tests_failed++; $display("FAIL p1_menu_winner got %0d want 0", bus.winner); end
    btn = 1'b0; p1 = 4'd0; step();
  endtask

  task automatic test_rst_mid_play();
    press_start();
    run_ticks(ST);
    x = 11'd0; tick = 1'b1; step(); tick = 1'b0; x = 11'd316;
    run_ticks(ST);
    tests_run++; if (bus.state !== PLAY || bus.serve_dir !== 1'b0) begin
      tests_failed++; $display("FAIL pre_rst_play got state %0d dir %b want 2/0", bus.state, bus.serve_dir);
    end
    x = 11'd0; tick = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; tick = 1'b0; x = 11'd316;
    tests_run++; if (bus.state !== MENU_START) begin tests_failed++; $display("FAIL rst_play_state got %0d want 0", bus.state); end
    tests_run++; if (bus.ball_hold !== 1'b1) begin tests_failed++; $display("FAIL rst_play_hold got %b want 1", bus.ball_hold); end
    tests_run++; if (bus.serve_dir !== 1'b1) begin tests_failed++; $display("FAIL rst_play_dir got %b want 1", bus.serve_dir); end
    tests_run++; if (bus.winner !== 2'd0) begin tests_failed++; $display("FAIL rst_play_winner got %0d want 0", bus.winner); end
    step();
  endtask

  task automatic test_random();
    int unsigned r;
    for (int i = 0; i < 6000; i++) begin
      tick = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      r = $urandom_range(0, 9);
      case (r)
        0: x = 11'd0;
        1: x = 11'(X_PAD_LEFT - 1);
        2: x = 11'(X_PAD_LEFT);
        3: x = 11'(X_PAD_RIGHT + PAD_WIDTH - BALL_SIZE);
        4: x = 11'(X_PAD_RIGHT + PAD_WIDTH - BALL_SIZE + 1);
        5: x = 11'd2047;
        6: x = 11'($urandom_range(0, 2047));
        default: x = 11'd316;
      endcase
      if ($urandom_range(0, 99) == 0) p1 = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 99) == 0) p2 = 4'($urandom_range(0, 9));
      rst = ($urandom_range(0, 999) == 0);
      step();
      tests_run++; if (bus.state !== m_state) begin tests_failed++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, bus.state, m_state); end
      tests_run++; if (bus.ball_hold !== m_hold) begin tests_failed++; $display("FAIL rnd_hold cyc %0d got %b want %b", i, bus.ball_hold, m_hold); end
      tests_run++; if (bus.serve_dir !== m_dir) begin tests_failed++; $display("FAIL rnd_dir cyc %0d got %b want %b", i, bus.serve_dir, m_dir); end
      tests_run++; if (bus.winner !== m_win) begin tests_failed++; $display("FAIL rnd_winner cyc %0d got %0d want %0d", i, bus.winner, m_win); end
    end
    rst = 1'b0; tick = 1'b0; btn = 1'b0; x = 11'd316; p1 = 4'd0; p2 = 4'd0;
    step(); step();
  endtask

  // Full game with the score counters emulated around the sequencer
  task automatic test_full_game();
    int         pend;
    int         points;
    logic [1:0] prev;
    bit         done;
    rst = 1'b1; step(); rst = 1'b0;
    p1 = 4'd0; p2 = 4'd0;
    press_start();
    pend = 0; points = 0; done = 1'b0;
    prev = bus.state;
    tick = 1'b1;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (bus.state == PLAY) x = ((points % 3 == 0) && p1 < 4'd5) ? 11'd700 : 11'd0;
      else x = 11'd316;
      step();
      if (pend == 1 && p1 < 4'd9) p1 = p1 + 4'd1;
      if (pend == 2 && p2 < 4'd9) p2 = p2 + 4'd1;
      pend = 0;
      if (prev == 2'd2 && bus.state == SERVE) begin
        pend = (bus.serve_dir == 1'b1) ? 1 : 2;
        points++;
      end
      if (bus.state == MENU_START) begin p1 = 4'd0; p2 = 4'd0; end
      prev = bus.state;
      if (bus.state == GAME_OVER) done = 1'b1;
    end
    tick = 1'b0; x = 11'd316;
    tests_run++; if (bus.state !== GAME_OVER) begin tests_failed++; $display("FAIL game_end got %0d want 3", bus.state); end
    tests_run++; if (bus.winner !== 2'd2 || m_win !== 2'd2) begin tests_failed++; $display("FAIL game_winner got %0d want 2", bus.winner); end
    tests_run++; if (p2 !== 4'd9 || p1 == 4'd0) begin tests_failed++; $display("FAIL game_score got %0d:%0d want n:9 with n>0", p1, p2); end
    btn = 1'b1; step(); btn = 1'b0;
    tests_run++; if (bus.state !== MENU_START) begin tests_failed++; $display("FAIL game_menu got %0d want 0", bus.state); end
    if (bus.state == MENU_START) begin p1 = 4'd0; p2 = 4'd0; end
    step();
    tests_run++; if (p1 !== 4'd0 || p2 !== 4'd0 || bus.state !== MENU_START) begin
      tests_failed++; $display("FAIL game_scores_clear got %0d:%0d state %0d want 0:0 state 0", p1, p2, bus.state);
    end
    tests_run++; if (bus.state !== m_state || bus.winner !== m_win) begin tests_failed++; $display("FAIL game_model got %0d/%0d want %0d/%0d", bus.state, bus.winner, m_state, m_win); end
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_left_exit();
    test_right_exit();
    test_p1_win();
    test_rst_mid_play();
    test_random();
    test_full_game();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
